// File: rtl/beu_seq.sv
// beu_seq: sequential bit-manipulation execution unit.
//
// Runs the Zbb-style single-cycle ops with a registered result. The Zbc
// carry-less multiplies (CLMUL, CLMULH, CLMULR) run as an iterative
// multi-cycle operation, consuming CLMUL_BPC multiplier bits per BUSY cycle.
//
// Optional feature macro: BEU_SEQ_CLMUL_EN
//   defined   : opcodes 0-2 run iteratively through the BUSY state.
//   undefined : no accumulator, counter or BUSY state is built. Opcodes 0-2
//               behave like reserved opcodes (1-cycle latency, result 0),
//               and s_busy_o is tied low.
//
// Parameters:
//   XLEN      operand/result width (power of two, >= 8)
//   CLMUL_BPC multiplier bits consumed per BUSY cycle (must divide XLEN)
//
// Ports:
//   s_clk_i     clock, rising edge
//   s_reset_i   synchronous active-high reset
//   s_valid_i   operation request
//   s_ready_o   unit can accept a request this cycle
//   s_op_i      opcode: 0 CLMUL, 1 CLMULH, 2 CLMULR, 3 CPOP, 4 CLZ, 5 CTZ,
//               6 ROL, 7 ROR, 8 ORCB, 9 REV8, 10 BEXT, 11 BSET, 12 BCLR,
//               13 BINV, 14-15 reserved (result 0)
//   s_op1_i     operand 1
//   s_op2_i     operand 2, or bit/shift index in its low log2(XLEN) bits
//   s_kill_i    flush; abandons any in-flight operation
//   s_valid_o   result valid
//   s_ready_i   consumer accepts the result
//   s_result_o  registered result
//   s_busy_o    high while a carry-less multiply is iterating

module beu_seq #(
  parameter int XLEN      = 32,
  parameter int CLMUL_BPC = 4
) (
  input  logic            s_clk_i,
  input  logic            s_reset_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [3:0]      s_op_i,
  input  logic [XLEN-1:0] s_op1_i,
  input  logic [XLEN-1:0] s_op2_i,
  input  logic            s_kill_i,
  output logic            s_valid_o,
  input  logic            s_ready_i,
  output logic [XLEN-1:0] s_result_o,
  output logic            s_busy_o
);

  localparam int IDXW   = $clog2(XLEN);
  localparam int NBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef BEU_SEQ_CLMUL_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic            accept;

  assign s_ready_o  = ~s_kill_i & ((state == IDLE) | ((state == DONE) & s_ready_i));
  assign accept     = s_valid_i & s_ready_o;
  assign s_valid_o  = valid_q;
  assign s_result_o = result_q;

  // Single-cycle datapath, evaluated straight from the request operands so
  // the result can be registered on the accept edge.
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   inv_sh;
  logic [XLEN-1:0] cpop_v, clz_v, ctz_v, orcb_v, rev8_v, onehot, single_res;
  logic            lz_seen, tz_seen;

  assign idx    = s_op2_i[IDXW-1:0];
  // Complementary shift for rotates; idx=0 gives a shift of XLEN, which
  // yields zero and so leaves op1 unchanged.
  assign inv_sh = (IDXW+1)'(XLEN) - {1'b0, idx};
  assign onehot = {{(XLEN-1){1'b0}}, 1'b1} << idx;

  always_comb begin
    cpop_v  = '0;
    clz_v   = '0;
    ctz_v   = '0;
    lz_seen = 1'b0;
    tz_seen = 1'b0;
    orcb_v  = '0;
    rev8_v  = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (s_op1_i[i]) cpop_v = cpop_v + XLEN'(1);
    end
    // Counting stops at the first set bit; an all-zero operand counts XLEN.
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (s_op1_i[i]) lz_seen = 1'b1;
      else if (!lz_seen) clz_v = clz_v + XLEN'(1);
    end
    for (int i = 0; i < XLEN; i++) begin
      if (s_op1_i[i]) tz_seen = 1'b1;
      else if (!tz_seen) ctz_v = ctz_v + XLEN'(1);
    end
    for (int b = 0; b < NBYTES; b++) begin
      orcb_v[8*b +: 8] = (|s_op1_i[8*b +: 8]) ? 8'hFF : 8'h00;
      rev8_v[8*b +: 8] = s_op1_i[8*(NBYTES-1-b) +: 8];
    end
  end

  always_comb begin
    single_res = '0;
    case (s_op_i)
      4'd3:    single_res = cpop_v;
      4'd4:    single_res = clz_v;
      4'd5:    single_res = ctz_v;
      4'd6:    single_res = (s_op1_i << idx) | (s_op1_i >> inv_sh);
      4'd7:    single_res = (s_op1_i >> idx) | (s_op1_i << inv_sh);
      4'd8:    single_res = orcb_v;
      4'd9:    single_res = rev8_v;
      4'd10:   single_res = {{(XLEN-1){1'b0}}, s_op1_i[idx]};
      4'd11:   single_res = s_op1_i | onehot;
      4'd12:   single_res = s_op1_i & ~onehot;
      4'd13:   single_res = s_op1_i ^ onehot;
      default: single_res = '0;
    endcase
  end

`ifdef BEU_SEQ_CLMUL_EN
  localparam int ITERS = XLEN / CLMUL_BPC;
  localparam int CNTW  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(ITERS - 1);

  logic                busy_q;
  logic [CNTW-1:0]     cnt_q;
  logic [2*XLEN-1:0]   acc_q, acc_next;
  // Multiplicand pre-shifted to the current chunk position, and the
  // multiplier shifted so its next chunk always sits in the low bits.
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [1:0]          sel_q;
  logic [XLEN-1:0]     clmul_res;

  assign s_busy_o = busy_q;

  always_comb begin
    acc_next = acc_q;
    for (int k = 0; k < CLMUL_BPC; k++) begin
      if (mplier_q[k]) acc_next = acc_next ^ (mcand_q << k);
    end
  end

  // Selection uses acc_next so the final chunk lands in the result on the
  // same edge that leaves BUSY.
  always_comb begin
    case (sel_q)
      2'd0:    clmul_res = acc_next[XLEN-1:0];
      2'd1:    clmul_res = acc_next[2*XLEN-1:XLEN];
      2'd2:    clmul_res = acc_next[2*XLEN-2:XLEN-1];
      default: clmul_res = '0;
    endcase
  end
`else
  logic unused_op2;

  assign s_busy_o   = 1'b0;
  assign unused_op2 = ^s_op2_i[XLEN-1:IDXW];
`endif

  // Control FSM with registered outputs. Kill outranks everything except
  // reset; in DONE an accept and a drain can happen on the same edge,
  // which gives back-to-back throughput.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
`ifdef BEU_SEQ_CLMUL_EN
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sel_q    <= '0;
`endif
    end else if (s_kill_i) begin
      state   <= IDLE;
      valid_q <= 1'b0;
`ifdef BEU_SEQ_CLMUL_EN
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state)
`ifdef BEU_SEQ_CLMUL_EN
        BUSY: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << CLMUL_BPC;
          mplier_q <= mplier_q >> CLMUL_BPC;
          cnt_q    <= cnt_q + CNTW'(1);
          if (cnt_q == LAST) begin
            result_q <= clmul_res;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state    <= DONE;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef BEU_SEQ_CLMUL_EN
            if (s_op_i <= 4'd2) begin
              acc_q    <= '0;
              cnt_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, s_op1_i};
              mplier_q <= s_op2_i;
              sel_q    <= s_op_i[1:0];
              busy_q   <= 1'b1;
              valid_q  <= 1'b0;
              state    <= BUSY;
            end else
`endif
            begin
              result_q <= single_res;
              valid_q  <= 1'b1;
              state    <= DONE;
            end
          end else if ((state == DONE) && s_ready_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beu_seq.sv
// Scoreboard testbench for beu_seq (XLEN=32, CLMUL_BPC=4).
// Stimulus pushes the hand-computed result and latency for each accepted
// request; a monitor on the falling edge pops and compares whenever the
// DUT presents a result. Expectations follow BEU_SEQ_CLMUL_EN.

module tb_beu_seq;

  logic        clk = 1'b0;
  logic        reset, valid_i, ready_o, kill, valid_o, ready_i, busy;
  logic [3:0]  op;
  logic [31:0] op1, op2, result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   busy_cnt     = 0;
  bit   presented    = 1'b0;

  always #5 clk = ~clk;

  beu_seq #(.XLEN(32), .CLMUL_BPC(4)) dut (
    .s_clk_i    (clk),
    .s_reset_i  (reset),
    .s_valid_i  (valid_i),
    .s_ready_o  (ready_o),
    .s_op_i     (op),
    .s_op1_i    (op1),
    .s_op2_i    (op2),
    .s_kill_i   (kill),
    .s_valid_o  (valid_o),
    .s_ready_i  (ready_i),
    .s_result_o (result),
    .s_busy_o   (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: latency is checked when a result first appears, the value when
  // the consumer takes it.
  always @(negedge clk) begin
    if (!reset && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        if (!presented) begin
          checkOutput({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
          presented = 1'b1;
        end
        if (ready_i) begin
          checkOutput({sb[0].name, "_result"}, result, sb[0].res);
          void'(sb.pop_front());
          presented = 1'b0;
        end
      end
    end
  end

  // Drive a request and hold it until accepted; returns one cycle after
  // the accept edge with s_valid_i dropped.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat, input bit expect_res,
                               input string name, output int waited);
    bit accepted = 1'b0;
    op = o; op1 = a; op2 = b; valid_i = 1'b1;
    waited = 0;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (ready_o) begin
        accepted = 1'b1;
        if (expect_res) sb.push_back('{exp, lat, cyc, name});
      end else begin
        waited++;
      end
    end
    if (!accepted) checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  t_op  [13];
    logic [31:0] t_a   [13];
    logic [31:0] t_b   [13];
    logic [31:0] t_exp [13];
    int w, b0;

    reset = 1'b1; valid_i = 1'b0; kill = 1'b0; ready_i = 1'b1;
    op = '0; op1 = '0; op2 = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops; each must be accepted without stalling.
    t_op[0]  = 4'd3;  t_a[0]  = 32'hF0F0F0F0; t_b[0]  = 32'd0;  t_exp[0]  = 32'd16;
    t_op[1]  = 4'd4;  t_a[1]  = 32'h00000000; t_b[1]  = 32'd0;  t_exp[1]  = 32'd32;
    t_op[2]  = 4'd7;  t_a[2]  = 32'h80000001; t_b[2]  = 32'd1;  t_exp[2]  = 32'hC0000000;
    t_op[3]  = 4'd9;  t_a[3]  = 32'h11223344; t_b[3]  = 32'd0;  t_exp[3]  = 32'h44332211;
    t_op[4]  = 4'd6;  t_a[4]  = 32'h12345678; t_b[4]  = 32'd0;  t_exp[4]  = 32'h12345678;
    t_op[5]  = 4'd6;  t_a[5]  = 32'h80000001; t_b[5]  = 32'd4;  t_exp[5]  = 32'h00000018;
    t_op[6]  = 4'd5;  t_a[6]  = 32'h00000000; t_b[6]  = 32'd0;  t_exp[6]  = 32'd32;
    t_op[7]  = 4'd5;  t_a[7]  = 32'h00000100; t_b[7]  = 32'd0;  t_exp[7]  = 32'd8;
    t_op[8]  = 4'd4;  t_a[8]  = 32'h00010000; t_b[8]  = 32'd0;  t_exp[8]  = 32'd15;
    t_op[9]  = 4'd11; t_a[9]  = 32'h00000000; t_b[9]  = 32'd31; t_exp[9]  = 32'h80000000;
    t_op[10] = 4'd12; t_a[10] = 32'hFFFFFFFF; t_b[10] = 32'd32; t_exp[10] = 32'hFFFFFFFE;
    t_op[11] = 4'd13; t_a[11] = 32'h000000F0; t_b[11] = 32'd4;  t_exp[11] = 32'h000000E0;
    t_op[12] = 4'd14; t_a[12] = 32'hDEADBEEF; t_b[12] = 32'd5;  t_exp[12] = 32'h00000000;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(t_op[i], t_a[i], t_b[i], t_exp[i], 1, 1'b1, $sformatf("single%0d", i), w);
      if (i > 0) checkOutput($sformatf("single%0d_stall", i), 32'(w), 32'd0);
    end
    waitDrain();

`ifdef BEU_SEQ_CLMUL_EN
    t_op[0] = 4'd0; t_a[0] = 32'h3;        t_b[0] = 32'h3;        t_exp[0] = 32'h5;
    t_op[1] = 4'd0; t_a[1] = 32'hFFFFFFFF; t_b[1] = 32'hFFFFFFFF; t_exp[1] = 32'h55555555;
    t_op[2] = 4'd1; t_a[2] = 32'hFFFFFFFF; t_b[2] = 32'hFFFFFFFF; t_exp[2] = 32'h55555555;
    t_op[3] = 4'd2; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'hFFFFFFFF; t_exp[3] = 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) begin
      b0 = busy_cnt;
      applyStimulus(t_op[i], t_a[i], t_b[i], t_exp[i], 9, 1'b1, $sformatf("clmul%0d", i), w);
      waitDrain();
      checkOutput($sformatf("clmul%0d_busy_cycles", i), 32'(busy_cnt - b0), 32'd8);
    end
`else
    applyStimulus(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 1'b1, "clmulh_disabled", w);
    applyStimulus(4'd0, 32'h3, 32'h3, 32'h0, 1, 1'b1, "clmul_disabled", w);
    waitDrain();
`endif

    // Output backpressure: result must hold while the consumer stalls.
    ready_i = 1'b0;
    applyStimulus(4'd10, 32'h8, 32'd3, 32'h1, 1, 1'b1, "bext", w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", i), 32'(valid_o), 32'd1);
      checkOutput($sformatf("bp%0d_result", i), result, 32'h1);
      checkOutput($sformatf("bp%0d_ready", i), 32'(ready_o), 32'd0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    applyStimulus(4'd3, 32'h000000FF, 32'd0, 32'd8, 1, 1'b1, "bp_next", w);
    checkOutput("bp_next_stall", 32'(w), 32'd0);
    waitDrain();

`ifdef BEU_SEQ_CLMUL_EN
    // Kill in the 4th BUSY cycle; the abandoned multiply must never appear.
    applyStimulus(4'd0, 32'h3, 32'h3, 32'h0, 9, 1'b0, "killed", w);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("kill_pre_busy", 32'(busy), 32'd1);
    kill = 1'b1;
    valid_i = 1'b1; op = 4'd8; op1 = 32'h12345678;
    @(negedge clk);
    checkOutput("kill_ready", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; valid_i = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    checkOutput("kill_valid", 32'(valid_o), 32'd0);
    checkOutput("kill_ready_after", 32'(ready_o), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("kill_no_result", 32'(valid_o), 32'd0);
`endif
    applyStimulus(4'd8, 32'h00FF0100, 32'd0, 32'h00FFFF00, 1, 1'b1, "orcb", w);
    waitDrain();

`ifndef BEU_SEQ_CLMUL_EN
    checkOutput("busy_never", 32'(busy_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/beu_seq.md
Name: beu_seq

Overview:
- Parametrised, sequential successor to the combinational bit-manipulation unit.
- Executes Zbb-style single-cycle ops with a registered result, plus the Zbc carry-less multiplies (CLMUL, CLMULH, CLMULR) as an iterative multi-cycle operation.
- Sits in the executor beside the ALU.
- Valid/ready on input and output; kill input for pipeline flush.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, 8 or more.
- CLMUL_BPC, 4, op2 bits consumed per BUSY cycle; must divide XLEN.

Ports:
- s_clk_i  input  1  clock; all state changes on its rising edge.
- s_reset_i  input  1  synchronous active-high reset.
- s_valid_i  input  1  operation request.
- s_ready_o  output  1  unit can accept a request this cycle.
- s_op_i  input  4  opcode: 0 CLMUL, 1 CLMULH, 2 CLMULR, 3 CPOP, 4 CLZ, 5 CTZ, 6 ROL, 7 ROR, 8 ORCB, 9 REV8, 10 BEXT, 11 BSET, 12 BCLR, 13 BINV; 14 and 15 reserved.
- s_op1_i  input  XLEN  operand 1.
- s_op2_i  input  XLEN  operand 2, or shift/bit index in bits [log2(XLEN)-1:0].
- s_kill_i  input  1  flush; abandons any in-flight operation.
- s_valid_o  output  1  result valid.
- s_ready_i  input  1  consumer accepts the result.
- s_result_o  output  XLEN  registered result.
- s_busy_o  output  1  high while in BUSY.

Behaviour:
- Synchronous, active-high reset, one clock.
- Reset values: state IDLE; s_valid_o=0; s_result_o=0; s_busy_o=0; iteration counter=0; product accumulator=0.
- FSM states: IDLE, BUSY, DONE.
- s_ready_o = ~s_kill_i & (IDLE | (DONE & s_ready_i)).
- Accept condition: s_valid_i & s_ready_o; operands are captured on that edge.
- Single-cycle ops (3-13): on accept, the result is written to s_result_o and the FSM enters DONE.
  - s_valid_o rises the cycle after accept (latency 1).
  - Back-to-back accepts while DONE & s_ready_i give throughput 1/cycle.
- CLMUL ops (0-2): on accept, enter BUSY with counter=0 and accumulator=0.
  - Each BUSY cycle, for each of the CLMUL_BPC op2 bits at positions counter*CLMUL_BPC+k, the accumulator XORs in (op1 << position) when that bit is set.
  - The accumulator is 2*XLEN wide.
  - After XLEN/CLMUL_BPC BUSY cycles, load s_result_o and enter DONE. With the defaults, s_valid_o is high 9 cycles after the accept edge.
- CLMUL result selection from product P:
  - CLMUL = P[XLEN-1:0]
  - CLMULH = P[2XLEN-1:XLEN]
  - CLMULR = P[2XLEN-2:XLEN-1]
- Arithmetic/width rules:
  - CPOP/CLZ/CTZ are zero-extended counts; CLZ(0) = CTZ(0) = XLEN.
  - ROL/ROR with shift amount 0 return op1 unchanged.
  - REV8 reverses the byte order across XLEN/8 bytes.
  - ORCB sets each nonzero byte to 0xFF and leaves zero bytes 0x00.
  - BEXT = {0, op1[idx]}.
  - BSET, BCLR and BINV act on op1 bit idx.
- Reserved opcodes are accepted and complete in 1 cycle with result 0.
- DONE holds s_valid_o and s_result_o stable until s_ready_i. On s_ready_i without a new accept, go to IDLE and clear s_valid_o.
- s_kill_i has priority over every other event. Next cycle: IDLE, s_valid_o=0, s_busy_o=0, counter=0. No request is accepted in a kill cycle. s_result_o keeps its old value but is don't-care.
- A kill during BUSY abandons the multiply; no result is ever presented for it.
- Reset asserted mid-operation behaves like kill and also forces all outputs to their reset values.
- Inputs other than the handshake signals are ignored outside the accept cycle.

Optional Feature:
- Macro BEU_SEQ_CLMUL_EN.
- Defined: CLMUL/CLMULH/CLMULR execute iteratively as described; BUSY is reachable.
- Undefined:
  - The accumulator, counter and BUSY state are not synthesised.
  - Opcodes 0-2 behave as reserved: 1-cycle latency, result 0.
  - s_busy_o is tied to 0.

Test Plan:
- Reset then idle: hold s_reset_i 2 cycles -> s_valid_o=0, s_result_o=0, s_ready_o=1, s_busy_o=0.
- Single-cycle ops, one request per cycle with s_ready_i=1 held: CPOP 0xF0F0F0F0, CLZ 0, ROR 0x80000001 by 1, REV8 0x11223344 -> results 16, 32, 0xC0000000, 0x44332211 on consecutive cycles starting 1 cycle after the first accept.
- CLMUL with macro defined: CLMUL 0x3, 0x3 -> 0x5. op1=op2=0xFFFFFFFF -> CLMUL 0x55555555, CLMULH 0x55555555, CLMULR 0xAAAAAAAA. Each valid 9 cycles after accept; s_busy_o high for exactly 8 cycles.
- Output backpressure: hold s_ready_i=0 for 5 cycles after the BEXT 0x8, idx 3 result appears -> s_valid_o=1 and s_result_o=0x1 stable, s_ready_o=0. Then raise s_ready_i -> next queued request is accepted that same cycle.
- Kill mid-BUSY: assert s_kill_i in the 4th BUSY cycle of a CLMUL -> next cycle IDLE, s_valid_o stays 0. A following ORCB 0x00FF0100 -> 0x00FFFF00 with latency 1.
- Macro undefined: CLMULH 0xFFFFFFFF, 0xFFFFFFFF -> result 0 valid 1 cycle after accept; s_busy_o never asserted.
